brick_field_state: RTL

Owns the 30-bit brick-alive mask that the brick renderer draws from. Once per frame it checks the latched ball rectangle against every live brick, clears the first brick it hits, and reports which axis the ball must reflect on. It sits between the ball/paddle physics block, which supplies the ball position and frame tick, and the VGA brick renderer, which consumes `bricksDisplay`.

---
 rtl/brick_field_state.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/brick_field_state.sv
// brick_field_state
// Owns the 30-bit brick-alive mask drawn by the brick renderer. Once per
// frame it walks all 30 bricks, one per cycle, and compares each against the
// latched ball square. The first live brick the ball overlaps is cleared,
// and the block reports which axis the ball must reflect on.
module brick_field_state #(
    parameter int startXCoord = 20,   // left edge of brick column 0
    parameter int startYCoord = 20,   // top edge of brick row 0
    parameter int brickXSize  = 100,  // brick width
    parameter int brickYSize  = 20,   // brick height
    parameter int ballSize    = 8     // ball square side
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frameTick,
    input  logic        newGame,
    input  logic [9:0]  ballX,
    input  logic [9:0]  ballY,
    output logic [29:0] bricksDisplay,
    output logic        hitValid,
    output logic [4:0]  hitIndex,
    output logic        bounceX,
    output logic        bounceY,
    output logic        scanDone,
    output logic        busy,
    output logic [4:0]  hitCount,
    output logic        allCleared
);

    // Geometry in 11 bits so that the far edges of bricks and ball never wrap.
    localparam logic [10:0] START_X   = 11'(startXCoord);
    localparam logic [10:0] START_Y   = 11'(startYCoord);
    localparam logic [10:0] BRICK_W   = 11'(brickXSize);
    localparam logic [10:0] BRICK_H   = 11'(brickYSize);
    localparam logic [10:0] BALL_SZ   = 11'(ballSize);
    localparam logic [10:0] BALL_HALF = 11'(ballSize / 2);

    localparam logic [29:0] ALL_ALIVE = 30'h3FFF_FFFF;
    localparam logic [4:0]  LAST_IDX  = 5'd29;
    localparam logic [2:0]  LAST_COL  = 3'd5;
    localparam logic [4:0]  MAX_HITS  = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HIT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q,     state_d;
    logic [4:0]  idx_q,       idx_d;        // brick under evaluation
    logic [2:0]  row_q,       row_d;        // idx / 6, tracked incrementally
    logic [2:0]  col_q,       col_d;        // idx % 6, tracked incrementally
    logic [9:0]  ball_x_q,    ball_x_d;     // ball position frozen for the scan
    logic [9:0]  ball_y_q,    ball_y_d;
    logic [29:0] mask_q,      mask_d;
    logic [4:0]  hit_index_q, hit_index_d;
    logic [4:0]  hit_count_q, hit_count_d;
    logic        bounce_x_q,  bounce_x_d;   // axis chosen for the pending hit

    // Geometry of the brick currently addressed by row/col.
    logic [10:0] brick_x0, brick_x1, brick_y0, brick_y1;
    logic [10:0] ball_x0, ball_x1, ball_y0, ball_y1;
    logic [10:0] centre_x;
    logic        overlap_x, overlap_y, overlap, centre_in_x;

    // Overlap test between the latched ball and the current brick.
    always_comb begin
        brick_x0    = START_X + 11'(col_q) * BRICK_W;
        brick_x1    = brick_x0 + BRICK_W;
        brick_y0    = START_Y + 11'(row_q) * BRICK_H;
        brick_y1    = brick_y0 + BRICK_H;
        ball_x0     = {1'b0, ball_x_q};
        ball_x1     = ball_x0 + BALL_SZ;
        ball_y0     = {1'b0, ball_y_q};
        ball_y1     = ball_y0 + BALL_SZ;
        centre_x    = ball_x0 + BALL_HALF;
        overlap_x   = (ball_x0 < brick_x1) && (brick_x0 < ball_x1);
        overlap_y   = (ball_y0 < brick_y1) && (brick_y0 < ball_y1);
        overlap     = overlap_x && overlap_y && mask_q[idx_q];
        // A ball whose centre sits over the brick hit it from above/below.
        centre_in_x = (centre_x >= brick_x0) && (centre_x < brick_x1);
    end

    // Next-state logic: scan sequencing, mask update and hit bookkeeping.
    always_comb begin
        // NOTE: every _d takes its _q value first so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        mask_d      = mask_q;
        hit_index_d = hit_index_q;
        hit_count_d = hit_count_q;
        bounce_x_d  = bounce_x_q;

        if (newGame) begin
            // Restart wins over everything, including a tick in the same cycle.
            state_d     = ST_IDLE;
            mask_d      = ALL_ALIVE;
            hit_count_d = 5'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frameTick) begin
                        ball_x_d = ballX;
                        ball_y_d = ballY;
                        idx_d    = 5'd0;
                        row_d    = 3'd0;
                        col_d    = 3'd0;
                        state_d  = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (overlap) begin
                        // Commit the hit now so the mask reads clear while the
                        // hit pulse is visible.
                        state_d             = ST_HIT;
                        mask_d[idx_q]       = 1'b0;
                        hit_index_d         = idx_q;
                        bounce_x_d          = !centre_in_x;
                        if (hit_count_q != MAX_HITS) begin
                            hit_count_d = hit_count_q + 5'd1;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (col_q == LAST_COL) begin
                            col_d = 3'd0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
                ST_HIT:  state_d = ST_IDLE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            ball_x_q    <= 10'd0;
            ball_y_q    <= 10'd0;
            mask_q      <= ALL_ALIVE;
            hit_index_q <= 5'd0;
            hit_count_q <= 5'd0;
            bounce_x_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            mask_q      <= mask_d;
            hit_index_q <= hit_index_d;
            hit_count_q <= hit_count_d;
            bounce_x_q  <= bounce_x_d;
        end
    end

    // Outputs decode directly from registered state, so pulses are glitch-free.
    always_comb begin
        bricksDisplay = mask_q;
        hitIndex      = hit_index_q;
        hitCount      = hit_count_q;
        allCleared    = (mask_q == 30'd0);
        busy          = (state_q != ST_IDLE);
        hitValid      = (state_q == ST_HIT);
        scanDone      = (state_q == ST_HIT) || (state_q == ST_DONE);
        bounceX       = (state_q == ST_HIT) && bounce_x_q;
        bounceY       = (state_q == ST_HIT) && !bounce_x_q;
    end

endmodule
